// File: rtl/password_fsm_if.sv
// Keypad/switch and status-display signal bundle for the password controller.
// The controller uses the slave view; the stimulus side uses the master view.
interface password_fsm_if;
    logic [3:0] sw;
    logic       key_enter_n;
    logic       key_clear_n;
    logic [2:0] state;
    logic [1:0] fail_count;
    logic       unlock;

    modport master (
        output sw,
        output key_enter_n,
        output key_clear_n,
        input  state,
        input  fail_count,
        input  unlock
    );

    modport slave (
        input  sw,
        input  key_enter_n,
        input  key_clear_n,
        output state,
        output fail_count,
        output unlock
    );
endinterface

// File: rtl/password_fsm.sv
// Four-digit password entry controller: synchronises and debounces the keys,
// checks digits against PASSWORD, and runs the error hold and lockout timers.
module password_fsm #(
    parameter logic [15:0] PASSWORD          = 16'h1234,
    parameter int          DEBOUNCE_CYCLES   = 500000,
    parameter int          ERROR_HOLD_CYCLES = 100000000,
    parameter int          MAX_FAILS         = 3,
    parameter int          LOCKOUT_CYCLES    = 500000000
) (
    input  logic          clk,
    input  logic          rst,
    password_fsm_if.slave bus
);

    localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TMR_MAX = (ERROR_HOLD_CYCLES > LOCKOUT_CYCLES) ? ERROR_HOLD_CYCLES : LOCKOUT_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [TMR_W-1:0] ERR_LAST = TMR_W'(ERROR_HOLD_CYCLES - 1);
    localparam logic [TMR_W-1:0] LCK_LAST = TMR_W'(LOCKOUT_CYCLES - 1);
    localparam logic [2:0]       MAX_F3   = 3'(MAX_FAILS);
    localparam logic [1:0]       MAX_F2   = 2'(MAX_FAILS);

    // Codes are fixed because the display decodes them directly.
    typedef enum logic [2:0] {
        ST_S0       = 3'b000,
        ST_S1       = 3'b001,
        ST_S2       = 3'b010,
        ST_S3       = 3'b011,
        ST_UNUSED   = 3'b100,
        ST_ERROR    = 3'b101,
        ST_COMPLETE = 3'b110,
        ST_LOCKOUT  = 3'b111
    } state_t;

    function automatic logic [3:0] f_digit(input logic [1:0] idx);
        logic [3:0] d;
        case (idx)
            2'd0:    d = PASSWORD[15:12];
            2'd1:    d = PASSWORD[11:8];
            2'd2:    d = PASSWORD[7:4];
            2'd3:    d = PASSWORD[3:0];
            default: d = 4'h0;
        endcase
        return d;
    endfunction

    // Index 0 is ENTER, index 1 is CLEAR throughout the key pipeline.
    logic [3:0]      r_sw_meta;
    logic [3:0]      r_sw_sync;
    logic [1:0]      r_key_meta;
    logic [1:0]      r_key_sync;
    logic [1:0]      r_key_db;
    logic [1:0]      r_key_db_d;
    logic [1:0]      r_key_ev;
    logic [DB_W-1:0] r_db_cnt [2];

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_mismatch;
    logic            w_mismatch_nxt;
    logic [1:0]      r_fail;
    logic [1:0]      w_fail_nxt;
    logic            r_unlock;
    logic            w_unlock_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [TMR_W-1:0] w_timer_nxt;

    logic            w_enter_ev;
    logic            w_clear_ev;
    logic            w_digit_bad;
    logic            w_any_bad;
    logic [2:0]      w_fail_inc;

    // Two-flop synchronisers for the switch bank and both raw keys.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sw_meta  <= 4'h0;
            r_sw_sync  <= 4'h0;
            r_key_meta <= 2'b11;
            r_key_sync <= 2'b11;
        end else begin
            r_sw_meta  <= bus.sw;
            r_sw_sync  <= r_sw_meta;
            r_key_meta <= {bus.key_clear_n, bus.key_enter_n};
            r_key_sync <= r_key_meta;
        end
    end

    // Debounce each key and register a one-cycle pulse on each debounced 1->0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_key_db   <= 2'b11;
            r_key_db_d <= 2'b11;
            r_key_ev   <= 2'b00;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= {DB_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (r_key_sync[i] == r_key_db[i]) begin
                    r_db_cnt[i] <= {DB_W{1'b0}};
                end else if (r_db_cnt[i] == DB_LAST) begin
                    r_key_db[i] <= r_key_sync[i];
                    r_db_cnt[i] <= {DB_W{1'b0}};
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + DB_W'(1);
                end
            end
            r_key_db_d <= r_key_db;
            r_key_ev   <= r_key_db_d & ~r_key_db;
        end
    end

    // CLEAR outranks ENTER, so a coincident ENTER is dropped here.
    assign w_clear_ev  = r_key_ev[1];
    assign w_enter_ev  = r_key_ev[0] & ~r_key_ev[1];
    assign w_digit_bad = (r_sw_sync != f_digit(r_state[1:0]));
    assign w_any_bad   = r_mismatch | w_digit_bad;
    assign w_fail_inc  = {1'b0, r_fail} + 3'd1;

    // Next-state, flag, counter and output decode.
    always_comb begin
        w_state_nxt    = r_state;
        w_mismatch_nxt = r_mismatch;
        w_fail_nxt     = r_fail;
        w_unlock_nxt   = 1'b0;
        w_timer_nxt    = {TMR_W{1'b0}};

        case (r_state)
            ST_S0: begin
                if (w_enter_ev) begin
                    w_mismatch_nxt = w_any_bad;
                    w_state_nxt    = ST_S1;
                end else begin
                    w_state_nxt    = ST_S0;
                end
            end
            ST_S1, ST_S2: begin
                if (w_clear_ev) begin
                    w_mismatch_nxt = 1'b0;
                    w_state_nxt    = ST_S0;
                end else if (w_enter_ev) begin
                    w_mismatch_nxt = w_any_bad;
                    w_state_nxt    = (r_state == ST_S1) ? ST_S2 : ST_S3;
                end else begin
                    w_state_nxt    = r_state;
                end
            end
            ST_S3: begin
                if (w_clear_ev) begin
                    w_mismatch_nxt = 1'b0;
                    w_state_nxt    = ST_S0;
                end else if (w_enter_ev) begin
                    w_mismatch_nxt = 1'b0;
                    if (!w_any_bad) begin
                        w_state_nxt  = ST_COMPLETE;
                        w_unlock_nxt = 1'b1;
                        w_fail_nxt   = 2'd0;
                    end else if (w_fail_inc < MAX_F3) begin
                        w_state_nxt  = ST_ERROR;
                        w_fail_nxt   = w_fail_inc[1:0];
                    end else begin
                        w_state_nxt  = ST_LOCKOUT;
                        w_fail_nxt   = MAX_F2;
                    end
                end else begin
                    w_state_nxt    = ST_S3;
                end
            end
            ST_ERROR: begin
                if (r_timer == ERR_LAST) begin
                    w_state_nxt = ST_S0;
                end else begin
                    w_state_nxt = ST_ERROR;
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            ST_LOCKOUT: begin
                if (r_timer == LCK_LAST) begin
                    w_state_nxt = ST_S0;
                    w_fail_nxt  = 2'd0;
                end else begin
                    w_state_nxt = ST_LOCKOUT;
                    w_timer_nxt = r_timer + TMR_W'(1);
                end
            end
            ST_COMPLETE: begin
                if (w_clear_ev) begin
                    w_state_nxt = ST_S0;
                end else begin
                    w_state_nxt = ST_COMPLETE;
                end
            end
            default: begin
                w_state_nxt    = ST_S0;
                w_mismatch_nxt = 1'b0;
            end
        endcase
    end

    // State register plus the registered status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_S0;
            r_mismatch <= 1'b0;
            r_fail     <= 2'd0;
            r_unlock   <= 1'b0;
            r_timer    <= {TMR_W{1'b0}};
        end else begin
            r_state    <= w_state_nxt;
            r_mismatch <= w_mismatch_nxt;
            r_fail     <= w_fail_nxt;
            r_unlock   <= w_unlock_nxt;
            r_timer    <= w_timer_nxt;
        end
    end

    assign bus.state      = r_state;
    assign bus.fail_count = r_fail;
    assign bus.unlock     = r_unlock;

endmodule

// File: tb/tb_password_fsm.sv
// Directed bench for password_fsm with short debounce and hold times so every
// timed path is exercised edge-accurately.
module tb_password_fsm;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks   = 0;
    int   n_errors   = 0;
    int   unlock_cnt = 0;

    password_fsm_if bus();

    password_fsm #(
        .PASSWORD          (16'h1234),
        .DEBOUNCE_CYCLES   (4),
        .ERROR_HOLD_CYCLES (8),
        .MAX_FAILS         (3),
        .LOCKOUT_CYCLES    (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.unlock === 1'b1) unlock_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // A press sampled from edge E updates the state on E+7, the 8th edge here.
    task automatic press_enter(input logic [3:0] d);
        bus.sw = d;
        bus.key_enter_n = 1'b0;
        tick(8);
    endtask

    task automatic release_enter();
        bus.key_enter_n = 1'b1;
        tick(8);
    endtask

    task automatic enter_digit(input logic [3:0] d);
        press_enter(d);
        release_enter();
    endtask

    task automatic press_clear();
        bus.key_clear_n = 1'b0;
        tick(8);
        bus.key_clear_n = 1'b1;
        tick(8);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(2);
        n_checks++; if (bus.state !== 3'b000) begin n_errors++; $display("FAIL rst_state got=%b exp=%b", bus.state, 3'b000); end
        n_checks++; if (bus.fail_count !== 2'd0) begin n_errors++; $display("FAIL rst_fail got=%0d exp=%0d", bus.fail_count, 0); end
        n_checks++; if (bus.unlock !== 1'b0) begin n_errors++; $display("FAIL rst_unlock got=%b exp=%b", bus.unlock, 1'b0); end
        rst = 1'b0;
        tick(4);
        n_checks++; if (bus.state !== 3'b000) begin n_errors++; $display("FAIL idle_state got=%b exp=%b", bus.state, 3'b000); end
    endtask

    task automatic test_unlock();
        int u0;
        u0 = unlock_cnt;
        enter_digit(4'h1);
        n_checks++; if (bus.state !== 3'b001) begin n_errors++; $display("FAIL ok_d1 got=%b exp=%b", bus.state, 3'b001); end
        enter_digit(4'h2);
        n_checks++; if (bus.state !== 3'b010) begin n_errors++; $display("FAIL ok_d2 got=%b exp=%b", bus.state, 3'b010); end
        enter_digit(4'h3);
        n_checks++; if (bus.state !== 3'b011) begin n_errors++; $display("FAIL ok_d3 got=%b exp=%b", bus.state, 3'b011); end
        press_enter(4'h4);
        n_checks++; if (bus.state !== 3'b110) begin n_errors++; $display("FAIL ok_complete got=%b exp=%b", bus.state, 3'b110); end
        n_checks++; if (bus.fail_count !== 2'd0) begin n_errors++; $display("FAIL ok_fail got=%0d exp=%0d", bus.fail_count, 0); end
        release_enter();
        n_checks++; if (bus.state !== 3'b110) begin n_errors++; $display("FAIL ok_hold got=%b exp=%b", bus.state, 3'b110); end
        n_checks++; if (unlock_cnt - u0 !== 1) begin n_errors++; $display("FAIL ok_unlock_cycles got=%0d exp=%0d", unlock_cnt - u0, 1); end
        press_clear();
        n_checks++; if (bus.state !== 3'b000) begin n_errors++; $display("FAIL ok_clear got=%b exp=%b", bus.state, 3'b000); end
    endtask

    task automatic test_error();
        enter_digit(4'h1);
        enter_digit(4'h9);
        n_checks++; if (bus.state !== 3'b010) begin n_errors++; $display("FAIL err_d2 got=%b exp=%b", bus.state, 3'b010); end
        enter_digit(4'h3);
        n_checks++; if (bus.state !== 3'b011) begin n_errors++; $display("FAIL err_d3 got=%b exp=%b", bus.state, 3'b011); end
        // 4-sample press, 4-sample release, then a second press whose event
        // lands on the last ERROR cycle and must be swallowed.
        bus.sw = 4'h4;
        bus.key_enter_n = 1'b0;
        tick(4);
        bus.key_enter_n = 1'b1;
        tick(4);
        n_checks++; if (bus.state !== 3'b101) begin n_errors++; $display("FAIL err_state got=%b exp=%b", bus.state, 3'b101); end
        n_checks++; if (bus.fail_count !== 2'd1) begin n_errors++; $display("FAIL err_fail got=%0d exp=%0d", bus.fail_count, 1); end
        bus.sw = 4'h1;
        bus.key_enter_n = 1'b0;
        tick(7);
        n_checks++; if (bus.state !== 3'b101) begin n_errors++; $display("FAIL err_hold7 got=%b exp=%b", bus.state, 3'b101); end
        tick(1);
        n_checks++; if (bus.state !== 3'b000) begin n_errors++; $display("FAIL err_exit8 got=%b exp=%b", bus.state, 3'b000); end
        bus.key_enter_n = 1'b1;
        tick(12);
        n_checks++; if (bus.state !== 3'b000) begin n_errors++; $display("FAIL err_enter_ignored got=%b exp=%b", bus.state, 3'b000); end
    endtask

    task automatic test_debounce();
        bus.sw = 4'h1;
        bus.key_enter_n = 1'b0;
        tick(3);
        bus.key_enter_n = 1'b1;
        tick(12);
        n_checks++; if (bus.state !== 3'b000) begin n_errors++; $display("FAIL glitch got=%b exp=%b", bus.state, 3'b000); end
        bus.key_enter_n = 1'b0;
        tick(7);
        n_checks++; if (bus.state !== 3'b000) begin n_errors++; $display("FAIL lat_e6 got=%b exp=%b", bus.state, 3'b000); end
        tick(1);
        n_checks++; if (bus.state !== 3'b001) begin n_errors++; $display("FAIL lat_e7 got=%b exp=%b", bus.state, 3'b001); end
        tick(92);
        n_checks++; if (bus.state !== 3'b001) begin n_errors++; $display("FAIL long_hold got=%b exp=%b", bus.state, 3'b001); end
        bus.key_enter_n = 1'b1;
        tick(10);
        n_checks++; if (bus.state !== 3'b001) begin n_errors++; $display("FAIL long_release got=%b exp=%b", bus.state, 3'b001); end
        press_clear();
        n_checks++; if (bus.state !== 3'b000) begin n_errors++; $display("FAIL db_clear got=%b exp=%b", bus.state, 3'b000); end
        n_checks++; if (bus.fail_count !== 2'd1) begin n_errors++; $display("FAIL db_fail got=%0d exp=%0d", bus.fail_count, 1); end
    endtask

    task automatic test_simultaneous();
        enter_digit(4'h1);
        enter_digit(4'h2);
        n_checks++; if (bus.state !== 3'b010) begin n_errors++; $display("FAIL sim_s2 got=%b exp=%b", bus.state, 3'b010); end
        bus.sw = 4'h3;
        bus.key_enter_n = 1'b0;
        bus.key_clear_n = 1'b0;
        tick(8);
        n_checks++; if (bus.state !== 3'b000) begin n_errors++; $display("FAIL sim_state got=%b exp=%b", bus.state, 3'b000); end
        n_checks++; if (bus.fail_count !== 2'd1) begin n_errors++; $display("FAIL sim_fail got=%0d exp=%0d", bus.fail_count, 1); end
        bus.key_enter_n = 1'b1;
        bus.key_clear_n = 1'b1;
        tick(8);
        enter_digit(4'h1);
        enter_digit(4'h2);
        enter_digit(4'h3);
        enter_digit(4'h4);
        n_checks++; if (bus.state !== 3'b110) begin n_errors++; $display("FAIL sim_after got=%b exp=%b", bus.state, 3'b110); end
        n_checks++; if (bus.fail_count !== 2'd0) begin n_errors++; $display("FAIL sim_after_fail got=%0d exp=%0d", bus.fail_count, 0); end
        press_clear();
    endtask

    task automatic wrong_to_error(input int k);
        enter_digit(4'h5);
        enter_digit(4'h5);
        enter_digit(4'h5);
        press_enter(4'h5);
        n_checks++; if (bus.state !== 3'b101) begin n_errors++; $display("FAIL b2b_err%0d got=%b exp=%b", k, bus.state, 3'b101); end
        n_checks++; if (bus.fail_count !== 2'(k)) begin n_errors++; $display("FAIL b2b_fail%0d got=%0d exp=%0d", k, bus.fail_count, k); end
        release_enter();
        n_checks++; if (bus.state !== 3'b000) begin n_errors++; $display("FAIL b2b_exit%0d got=%b exp=%b", k, bus.state, 3'b000); end
    endtask

    task automatic test_back_to_back();
        wrong_to_error(1);
        wrong_to_error(2);
        enter_digit(4'h5);
        enter_digit(4'h5);
        enter_digit(4'h5);
        press_enter(4'h5);
        n_checks++; if (bus.state !== 3'b111) begin n_errors++; $display("FAIL lock_state got=%b exp=%b", bus.state, 3'b111); end
        n_checks++; if (bus.fail_count !== 2'd3) begin n_errors++; $display("FAIL lock_fail got=%0d exp=%0d", bus.fail_count, 3); end
        bus.key_enter_n = 1'b1;
        tick(5);
        bus.key_clear_n = 1'b0;
        tick(1);
        bus.sw = 4'h1;
        bus.key_enter_n = 1'b0;
        tick(6);
        n_checks++; if (bus.state !== 3'b111) begin n_errors++; $display("FAIL lock_keys got=%b exp=%b", bus.state, 3'b111); end
        bus.key_clear_n = 1'b1;
        tick(3);
        n_checks++; if (bus.state !== 3'b111) begin n_errors++; $display("FAIL lock_hold15 got=%b exp=%b", bus.state, 3'b111); end
        tick(1);
        n_checks++; if (bus.state !== 3'b000) begin n_errors++; $display("FAIL lock_exit16 got=%b exp=%b", bus.state, 3'b000); end
        n_checks++; if (bus.fail_count !== 2'd0) begin n_errors++; $display("FAIL lock_exit_fail got=%0d exp=%0d", bus.fail_count, 0); end
        bus.key_enter_n = 1'b1;
        tick(12);
        n_checks++; if (bus.state !== 3'b000) begin n_errors++; $display("FAIL lock_after got=%b exp=%b", bus.state, 3'b000); end
        enter_digit(4'h1);
        enter_digit(4'h2);
        enter_digit(4'h3);
        enter_digit(4'h4);
        n_checks++; if (bus.state !== 3'b110) begin n_errors++; $display("FAIL lock_recover got=%b exp=%b", bus.state, 3'b110); end
        press_clear();
    endtask

    task automatic test_async_reset();
        enter_digit(4'h1);
        enter_digit(4'h2);
        n_checks++; if (bus.state !== 3'b010) begin n_errors++; $display("FAIL ar_s2 got=%b exp=%b", bus.state, 3'b010); end
        #3;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.state !== 3'b000) begin n_errors++; $display("FAIL ar_s2_state got=%b exp=%b", bus.state, 3'b000); end
        tick(2);
        rst = 1'b0;
        tick(2);
        enter_digit(4'h1);
        enter_digit(4'h2);
        enter_digit(4'h3);
        enter_digit(4'h4);
        n_checks++; if (bus.state !== 3'b110) begin n_errors++; $display("FAIL ar_entry1 got=%b exp=%b", bus.state, 3'b110); end
        press_clear();
        wrong_to_error(1);
        wrong_to_error(2);
        enter_digit(4'h5);
        enter_digit(4'h5);
        enter_digit(4'h5);
        press_enter(4'h5);
        bus.key_enter_n = 1'b1;
        tick(5);
        n_checks++; if (bus.state !== 3'b111) begin n_errors++; $display("FAIL ar_lock got=%b exp=%b", bus.state, 3'b111); end
        #3;
        rst = 1'b1;
        #1;
        n_checks++; if (bus.state !== 3'b000) begin n_errors++; $display("FAIL ar_lock_state got=%b exp=%b", bus.state, 3'b000); end
        n_checks++; if (bus.fail_count !== 2'd0) begin n_errors++; $display("FAIL ar_lock_fail got=%0d exp=%0d", bus.fail_count, 0); end
        n_checks++; if (bus.unlock !== 1'b0) begin n_errors++; $display("FAIL ar_lock_unlock got=%b exp=%b", bus.unlock, 1'b0); end
        tick(2);
        rst = 1'b0;
        tick(4);
        enter_digit(4'h1);
        enter_digit(4'h2);
        enter_digit(4'h3);
        enter_digit(4'h4);
        n_checks++; if (bus.state !== 3'b110) begin n_errors++; $display("FAIL ar_entry2 got=%b exp=%b", bus.state, 3'b110); end
        n_checks++; if (bus.fail_count !== 2'd0) begin n_errors++; $display("FAIL ar_entry2_fail got=%0d exp=%0d", bus.fail_count, 0); end
    endtask

    initial begin
        bus.sw          = 4'h0;
        bus.key_enter_n = 1'b1;
        bus.key_clear_n = 1'b1;
        test_reset();
        test_unlock();
        test_error();
        test_debounce();
        test_simultaneous();
        test_back_to_back();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
